srl_fifo_enq_arb: RTL and testbench
===================================

# srl_fifo_enq_arb

Message-locked round-robin arbiter that shares the enqueue side of one SRL FIFO (width `WIDTH+TAGW+1`, FULL_N/ENQ/D_IN interface) among `NREQ` producers. It grants one producer at a time and holds that grant until the producer's end-of-message word is enqueued. Each accepted word is tagged with its source index and EOM flag, so the consumer behind the FIFO can demultiplex. It sits directly in front of the FIFO in the ingress path.

## Interface
- `WIDTH`, 32: payload bits per word.
- `NREQ`, 4: number of requesters, 2..16.
- `TAGW`, `$clog2(NREQ)`: source-tag width. Derived; not overridden.
- `STALL_LIMIT`, 64: idle cycles tolerated inside a locked message. Used only with the macro.

Ports:
- `CLK` in 1: the single clock.
- `RST` in 1: synchronous, active-high reset.
- `REQ_VAL` in `NREQ`: requester i has a word.
- `REQ_EOM` in `NREQ`: requester i's current word ends its message.
- `REQ_DATA` in `NREQ*WIDTH`: requester i's word in bits `[i*WIDTH +: WIDTH]`.
- `REQ_TAKE` out `NREQ`: word of requester i is consumed this cycle.
- `FIFO_FULL_N` in 1: FIFO can accept a word.
- `FIFO_ENQ` out 1: enqueue strobe.
- `FIFO_D_IN` out `WIDTH+TAGW+1`: `{tag, eom, data}`.
- `GRANT` out `NREQ`: one-hot registered grant; all zero when idle.
- `BUSY` out 1: a message is locked.
- `STALL_ERR` out 1: one-cycle pulse on watchdog release. Tied 0 without the macro.

## Operation
- States:
  - IDLE: `GRANT` is 0.
  - LOCK: `GRANT` is one-hot, `BUSY` is 1.
- IDLE to LOCK: happens when any `REQ_VAL` is set. The winner is the first requester with `REQ_VAL` set, scanning from `ptr` upward and wrapping modulo `NREQ`. `GRANT` and `tag` are registered.
- In LOCK with grant g, a word transfers when `REQ_VAL[g] && FIFO_FULL_N`. That cycle:
  - `FIFO_ENQ` = 1.
  - `REQ_TAKE[g]` = 1.
  - `FIFO_D_IN` = `{g, REQ_EOM[g], REQ_DATA[g]}`.
- All other `REQ_TAKE` bits are always 0.
- `FIFO_ENQ`, `REQ_TAKE` and `FIFO_D_IN` are combinational from the registered grant and the inputs. They never depend combinationally on non-granted requesters.
- LOCK to IDLE: happens on a transfer with EOM set. `ptr` is set to (g+1) mod `NREQ`.
- A single-word message (EOM on its first word) is legal and takes one LOCK cycle.
- FIFO full (`FIFO_FULL_N`=0): no transfer. Grant and state hold; no word is dropped or duplicated.
- `REQ_VAL[g]`=0 in LOCK: state holds and nothing is enqueued.
- Other requesters asserting `REQ_VAL` during LOCK are ignored until IDLE.
- `REQ_VAL` of a non-granted requester has no effect on `FIFO_D_IN` contents.
- Reset mid-message:
  - Next edge forces IDLE, `GRANT`=0 and `ptr`=0.
  - The partial message already in the FIFO is not retracted. The FIFO's own reset/CLR is the system's responsibility.

## Timing
- Reset values:
  - `GRANT`=0, `BUSY`=0, `FIFO_ENQ`=0, `REQ_TAKE`=0, `STALL_ERR`=0.
  - `FIFO_D_IN` is don't-care.
  - `ptr`=0, so requester 0 has priority first.
- Arbitration latency: a request seen at edge n gets a grant after edge n. The first word can transfer in cycle n+1.
- Re-arbitration bubble: exactly one IDLE cycle between the EOM transfer and the next grant.
- Peak throughput with the FIFO never full:
  - A message of L words occupies L+1 cycles.
  - Continuous requesters see grants rotate 0,1,2,…,NREQ-1,0.
- The FIFO's own enqueue-to-EMPTY_N latency is outside this block.

## Configuration
- `SRL_FIFO_ENQ_ARB_STALL_TIMEOUT_EN` defined:
  - In LOCK, a counter increments on each cycle with `REQ_VAL[g]`=0 and resets on any cycle with `REQ_VAL[g]`=1.
  - When the counter reaches `STALL_LIMIT`:
    - The arbiter returns to IDLE and sets `ptr`=(g+1) mod `NREQ`.
    - `STALL_ERR` pulses for 1 cycle.
    - No EOM word is fabricated into the FIFO.
  - The counter clears on entering LOCK and on reset.
- Not defined: no counter is instantiated, `STALL_ERR` is constant 0, and a stalled requester holds the lock indefinitely.
- `FIFO_FULL_N`=0 cycles never count toward stall.

## Structure
- A shared package `srl_fifo_arb_pkg` holds:
  - The state enum (IDLE, LOCK).
  - A function computing the rotating first-set index from a request vector and `ptr`.
  - Localparam helpers for `TAGW` and the packed-word layout (tag, eom and data field offsets).
- One sub-module is natural: `rr_pick`. It is a combinational rotate-priority encoder taking a request vector and `ptr`, and returning a one-hot grant plus an index. It is reusable by the dequeue-side scheduler.
- The FIFO is not instantiated here; it is connected at the parent level.

## Test plan
- Reset release with `REQ_VAL`=0b0000: `GRANT`=0, `FIFO_ENQ`=0 for 10 cycles, `STALL_ERR`=0.
- `NREQ`=4, all requesters continuously valid with 2-word messages, FIFO never full: grants 0,1,2,3,0. Each message uses 3 cycles, and `FIFO_D_IN` tags match the grant with EOM on the 2nd word.
- Requester 2 sends 4 words; `FIFO_FULL_N`=0 during words 2–3 for 5 cycles: exactly 4 enqueues, order preserved, `GRANT` held at 0b0100 throughout, no `REQ_TAKE` while full.
- Requester 1 locked while requester 3 raises `REQ_VAL`: requester 3 gets no `REQ_TAKE` until requester 1's EOM transfers. Requester 3's grant follows after one idle cycle.
- `RST` asserted on the second word of a 5-word message: next cycle `GRANT`=0, `BUSY`=0. After release, requester 0 wins over requester 1 when both request.
- Macro defined, `STALL_LIMIT`=8: locked requester drops `REQ_VAL` for 8 cycles, then `STALL_ERR` pulses once and the arbiter grants the next requester. Without the macro, the grant holds for 100 cycles.

Source files
------------

// File: rtl/srl_fifo_arb_pkg.sv
// Shared types and helpers for the SRL FIFO enqueue arbiter and rr_pick.
// Optional stall watchdog in the top is enabled by SRL_FIFO_ENQ_ARB_STALL_TIMEOUT_EN.
package srl_fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    localparam int MAX_REQ  = 16;
    localparam int MAX_IDXW = 4;

    function automatic int tag_w(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    // Packed FIFO word is {tag, eom, data} with data at bit 0.
    function automatic int eom_pos(input int width);
        return width;
    endfunction

    function automatic int tag_lsb(input int width);
        return width + 1;
    endfunction

    // Returns {found, index} of the first set request scanning up from ptr, wrapping at nreq.
    function automatic logic [MAX_IDXW:0] rr_first(input logic [MAX_REQ-1:0] req,
                                                   input int ptr, input int nreq);
        logic [MAX_IDXW:0] res;
        int idx;
        res = '0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < nreq) begin
                idx = (ptr + k) % nreq;
                if (req[idx[MAX_IDXW-1:0]]) begin
                    res = {1'b1, idx[MAX_IDXW-1:0]};
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority encoder: one-hot grant and index of the first
// request at or above ptr_i, wrapping modulo NREQ.
module rr_pick
    import srl_fifo_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDXW = tag_w(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDXW-1:0] ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDXW-1:0] idx_o,
    output logic            any_o
);

    logic [MAX_REQ-1:0]  req_ext;
    logic [MAX_IDXW:0]   first;
    logic [MAX_IDXW-1:0] first_idx;

    always_comb begin
        req_ext             = '0;
        req_ext[NREQ-1:0]   = req_i;
        first               = rr_first(req_ext, int'(ptr_i), NREQ);
    end

    assign first_idx = first[MAX_IDXW-1:0];
    assign idx_o     = IDXW'(first_idx);
    assign any_o     = first[MAX_IDXW];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
            assign gnt_o[gi] = any_o && (idx_o == IDXW'(gi));
        end
    endgenerate

endmodule

// File: rtl/srl_fifo_enq_arb.sv
// Message-locked round-robin arbiter sharing one SRL FIFO enqueue port among NREQ producers.
// Define SRL_FIFO_ENQ_ARB_STALL_TIMEOUT_EN to add the stalled-lock watchdog (STALL_ERR).
module srl_fifo_enq_arb
    import srl_fifo_arb_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int NREQ        = 4,
    parameter int TAGW        = tag_w(NREQ),
    parameter int STALL_LIMIT = 64
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NREQ-1:0]         REQ_VAL,
    input  logic [NREQ-1:0]         REQ_EOM,
    input  logic [NREQ*WIDTH-1:0]   REQ_DATA,
    output logic [NREQ-1:0]         REQ_TAKE,
    input  logic                    FIFO_FULL_N,
    output logic                    FIFO_ENQ,
    output logic [WIDTH+TAGW:0]     FIFO_D_IN,
    output logic [NREQ-1:0]         GRANT,
    output logic                    BUSY,
    output logic                    STALL_ERR
);

    localparam int EOM_POS = eom_pos(WIDTH);
    localparam int TAG_LSB = tag_lsb(WIDTH);

    arb_state_e      state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [TAGW-1:0] gidx_q, gidx_d;
    logic [TAGW-1:0] ptr_q, ptr_d;
    logic [TAGW-1:0] ptr_after;
    logic [NREQ-1:0] pick_gnt;
    logic [TAGW-1:0] pick_idx;
    logic            pick_any;
    logic            xfer;
    logic            eom_xfer;
    logic            stall_hit;
    logic [WIDTH-1:0] req_word [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_word
            assign req_word[gi] = REQ_DATA[gi*WIDTH +: WIDTH];
        end
    endgenerate

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (TAGW)
    ) u_pick (
        .req_i (REQ_VAL),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Datapath is steered only by the registered grant index, never by other requesters.
    assign xfer      = (state_q == ST_LOCK) && REQ_VAL[gidx_q] && FIFO_FULL_N;
    assign eom_xfer  = xfer && REQ_EOM[gidx_q];
    assign ptr_after = (gidx_q == TAGW'(NREQ - 1)) ? '0 : gidx_q + TAGW'(1);

    always_comb begin
        FIFO_D_IN                     = '0;
        FIFO_D_IN[WIDTH-1:0]          = req_word[gidx_q];
        FIFO_D_IN[EOM_POS]            = REQ_EOM[gidx_q];
        FIFO_D_IN[TAG_LSB +: TAGW]    = gidx_q;
    end

    assign FIFO_ENQ = xfer;
    assign REQ_TAKE = xfer ? grant_q : '0;
    assign GRANT    = grant_q;
    assign BUSY     = (state_q == ST_LOCK);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_LOCK;
                    grant_d = pick_gnt;
                    gidx_d  = pick_idx;
                end
            end
            ST_LOCK: begin
                if (eom_xfer || stall_hit) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = ptr_after;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef SRL_FIFO_ENQ_ARB_STALL_TIMEOUT_EN
    localparam int CNTW = $clog2(STALL_LIMIT + 1);

    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
    logic            stall_err_q;

    // Only cycles where the FIFO could have accepted a word count as stalled.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        stall_hit   = 1'b0;
        if (state_q != ST_LOCK || REQ_VAL[gidx_q]) begin
            stall_cnt_d = '0;
        end else if (FIFO_FULL_N) begin
            if (stall_cnt_q == CNTW'(STALL_LIMIT - 1)) begin
                stall_hit   = 1'b1;
                stall_cnt_d = '0;
            end else begin
                stall_cnt_d = stall_cnt_q + CNTW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_q <= '0;
            stall_err_q <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            stall_err_q <= stall_hit;
        end
    end

    assign STALL_ERR = stall_err_q;
`else
    logic unused_stall_cfg;
    assign unused_stall_cfg = (STALL_LIMIT > 0);
    assign stall_hit        = 1'b0;
    assign STALL_ERR        = 1'b0;
`endif

endmodule

// File: tb/tb_srl_fifo_enq_arb.sv
// Randomised and directed bench for srl_fifo_enq_arb against a message-level reference model.
// Follows SRL_FIFO_ENQ_ARB_STALL_TIMEOUT_EN to choose the watchdog or the hold-forever scenario.
module tb_srl_fifo_enq_arb;

    localparam int WIDTH       = 32;
    localparam int NREQ        = 4;
    localparam int STALL_LIMIT = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_val, req_eom, req_take, grant;
    logic [NREQ*WIDTH-1:0] req_data;
    logic                  full_n, enq, busy, stall_err;
    logic [WIDTH+2:0]      din;

    always #5 clk = ~clk;

    srl_fifo_enq_arb #(
        .WIDTH       (WIDTH),
        .NREQ        (NREQ),
        .STALL_LIMIT (STALL_LIMIT)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .REQ_VAL     (req_val),
        .REQ_EOM     (req_eom),
        .REQ_DATA    (req_data),
        .REQ_TAKE    (req_take),
        .FIFO_FULL_N (full_n),
        .FIFO_ENQ    (enq),
        .FIFO_D_IN   (din),
        .GRANT       (grant),
        .BUSY        (busy),
        .STALL_ERR   (stall_err)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: which requester owns the lock, and where the next scan starts.
    bit          m_busy, m_err;
    int          m_g, m_ptr, m_cnt;
    bit          exp_xfer;
    logic [45:0] exp_vec;

    // Producers: word position inside message, message number, message length.
    int wpos[NREQ], msgn[NREQ], mlen[NREQ];
    bit rand_len;

    function automatic logic [45:0] obs_vec();
        return {grant, busy, enq, req_take, stall_err, enq ? din : 35'b0};
    endfunction

    task automatic reset_producers(input int len);
        for (int i = 0; i < NREQ; i++) begin
            wpos[i] = 0;
            msgn[i] = 0;
            mlen[i] = len;
        end
        rand_len = 1'b0;
    endtask

    task automatic settle();
        logic [3:0]  g1h;
        logic [34:0] d;
        for (int i = 0; i < NREQ; i++) begin
            req_eom[i] = (wpos[i] == mlen[i] - 1);
            req_data[i*WIDTH +: WIDTH] = {8'(i), 8'(msgn[i]), 16'(wpos[i])};
        end
        #2;
        g1h      = m_busy ? 4'(1 << m_g) : 4'b0;
        exp_xfer = m_busy && req_val[m_g] && full_n;
        d        = {2'(m_g), req_eom[m_g], req_data[m_g*WIDTH +: WIDTH]};
        exp_vec  = {g1h, m_busy, exp_xfer, exp_xfer ? g1h : 4'b0, m_err, exp_xfer ? d : 35'b0};
    endtask

    task automatic tick();
        int idx;
        @(posedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (exp_xfer && m_g == i) begin
                if (wpos[i] == mlen[i] - 1) begin
                    wpos[i] = 0;
                    msgn[i]++;
                    if (rand_len) mlen[i] = $urandom_range(1, 4);
                end else begin
                    wpos[i]++;
                end
            end
        end
        if (rst) begin
            m_busy = 0; m_ptr = 0; m_cnt = 0; m_err = 0;
        end else if (!m_busy) begin
            m_err = 0;
            m_cnt = 0;
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (req_val[idx]) begin
                    m_busy = 1;
                    m_g    = idx;
                    break;
                end
            end
        end else begin
            m_err = 0;
            if (exp_xfer && req_eom[m_g]) begin
                m_busy = 0;
                m_ptr  = (m_g + 1) % NREQ;
                m_cnt  = 0;
            end
`ifdef SRL_FIFO_ENQ_ARB_STALL_TIMEOUT_EN
            else if (req_val[m_g]) begin
                m_cnt = 0;
            end else if (full_n) begin
                m_cnt++;
                if (m_cnt == STALL_LIMIT) begin
                    m_busy = 0;
                    m_ptr  = (m_g + 1) % NREQ;
                    m_err  = 1;
                    m_cnt  = 0;
                end
            end
`endif
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_val = '0; full_n = 1'b1;
        reset_producers(1);
        settle(); tick();
        settle(); tick();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            settle();
            vectors++;
            if (obs_vec() !== exp_vec) begin
                miscompares++;
                $display("FAIL reset_model cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec);
            end
            vectors++;
            if (grant !== 4'b0 || enq !== 1'b0 || stall_err !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_idle cyc=%0d got grant=%b enq=%b err=%b busy=%b exp all 0",
                         c, grant, enq, stall_err, busy);
            end
            tick();
        end
    endtask

    task automatic test_rotation();
        int order[$];
        int rise[$];
        int wcnt;
        int gi;
        logic [3:0] prev_g;
        reset_producers(2);
        req_val = 4'hF; full_n = 1'b1;
        prev_g = 4'b0;
        wcnt = 0;
        for (int c = 0; c < 15; c++) begin
            settle();
            vectors++;
            if (obs_vec() !== exp_vec) begin
                miscompares++;
                $display("FAIL rotation cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec);
            end
            gi = -1;
            for (int i = 0; i < NREQ; i++) if (grant[i] === 1'b1) gi = i;
            if (grant !== 4'b0 && prev_g === 4'b0) begin
                order.push_back(gi);
                rise.push_back(c);
                wcnt = 0;
            end
            if (enq === 1'b1) begin
                vectors++;
                if (int'(din[34:33]) != gi || din[32] !== (wcnt == 1)) begin
                    miscompares++;
                    $display("FAIL rotation_tag cyc=%0d got tag=%0d eom=%b exp tag=%0d eom=%b",
                             c, din[34:33], din[32], gi, (wcnt == 1));
                end
                wcnt++;
            end
            prev_g = grant;
            tick();
        end
        req_val = '0;
        vectors++;
        if (order.size() != 5) begin
            miscompares++;
            $display("FAIL rotation_count got=%0d exp=5", order.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                vectors++;
                if (order[k] != k % NREQ) begin
                    miscompares++;
                    $display("FAIL rotation_order k=%0d got=%0d exp=%0d", k, order[k], k % NREQ);
                end
                if (k > 0) begin
                    vectors++;
                    if (rise[k] - rise[k-1] != 3) begin
                        miscompares++;
                        $display("FAIL rotation_period k=%0d got=%0d exp=3", k, rise[k] - rise[k-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_full_stall();
        int sent = 0;
        int lowc = 0;
        reset_producers(4);
        for (int c = 0; c < 12; c++) begin
            req_val = (sent < 4) ? 4'b0100 : 4'b0000;
            if (sent >= 1 && lowc < 5) begin
                full_n = 1'b0;
                lowc++;
            end else begin
                full_n = 1'b1;
            end
            settle();
            vectors++;
            if (obs_vec() !== exp_vec) begin
                miscompares++;
                $display("FAIL full_model cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec);
            end
            if (busy === 1'b1) begin
                vectors++;
                if (grant !== 4'b0100) begin
                    miscompares++;
                    $display("FAIL full_grant_hold cyc=%0d got=%b exp=0100", c, grant);
                end
            end
            if (!full_n) begin
                vectors++;
                if (req_take !== 4'b0) begin
                    miscompares++;
                    $display("FAIL full_take cyc=%0d got=%b exp=0000", c, req_take);
                end
            end
            if (enq === 1'b1) begin
                vectors++;
                if (din[15:0] !== 16'(sent) || din[34:33] !== 2'd2 || din[32] !== (sent == 3)) begin
                    miscompares++;
                    $display("FAIL full_order cyc=%0d got seq=%0d tag=%0d eom=%b exp seq=%0d tag=2 eom=%b",
                             c, din[15:0], din[34:33], din[32], sent, (sent == 3));
                end
                sent++;
            end
            tick();
        end
        full_n = 1'b1; req_val = '0;
        vectors++;
        if (sent != 4) begin
            miscompares++;
            $display("FAIL full_enq_count got=%0d exp=4", sent);
        end
    endtask

    task automatic test_lock_ignore();
        bit done1 = 0;
        bit done3 = 0;
        int e1 = -1;
        int g3 = -1;
        reset_producers(3);
        mlen[3] = 2;
        for (int c = 0; c < 10; c++) begin
            req_val = '0;
            req_val[1] = !done1 && (c != 2);
            req_val[3] = (c >= 2) && !done3;
            settle();
            vectors++;
            if (obs_vec() !== exp_vec) begin
                miscompares++;
                $display("FAIL lock_model cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec);
            end
            if (e1 < 0) begin
                vectors++;
                if (req_take[3] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL lock_early_take3 cyc=%0d got=%b exp=0", c, req_take[3]);
                end
            end
            if (g3 < 0 && grant === 4'b1000) g3 = c;
            if (exp_xfer && m_g == 1 && req_eom[1]) begin done1 = 1; e1 = c; end
            if (exp_xfer && m_g == 3 && req_eom[3]) done3 = 1;
            tick();
        end
        req_val = '0;
        vectors++;
        if (e1 < 0 || g3 != e1 + 2) begin
            miscompares++;
            $display("FAIL lock_rearb got grant3 cyc=%0d exp=%0d", g3, e1 + 2);
        end
    endtask

    task automatic test_reset_mid();
        reset_producers(1);
        mlen[2] = 5;
        for (int c = 0; c < 7; c++) begin
            rst = (c == 4);
            case (c)
                0, 1:    req_val = 4'b0001;
                2, 3, 4: req_val = 4'b0100;
                default: req_val = 4'b0011;
            endcase
            settle();
            vectors++;
            if (obs_vec() !== exp_vec) begin
                miscompares++;
                $display("FAIL rstmid_model cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec);
            end
            if (c == 5) begin
                vectors++;
                if (grant !== 4'b0 || busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rstmid_clear got grant=%b busy=%b exp 0000/0", grant, busy);
                end
            end
            if (c == 6) begin
                vectors++;
                if (grant !== 4'b0001) begin
                    miscompares++;
                    $display("FAIL rstmid_ptr got grant=%b exp=0001", grant);
                end
            end
            tick();
        end
        rst = 1'b0; req_val = '0;
    endtask

    task automatic test_stall();
        int  pulses = 0;
        bit  got_next = 0;
        reset_producers(3);
        mlen[2] = 1;
`ifdef SRL_FIFO_ENQ_ARB_STALL_TIMEOUT_EN
        for (int c = 0; c < 14; c++) begin
            req_val = 4'b0100 | ((c < 2) ? 4'b0010 : 4'b0000);
            settle();
            vectors++;
            if (obs_vec() !== exp_vec) begin
                miscompares++;
                $display("FAIL stall_model cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec);
            end
            if (pulses > 0 && !got_next && grant !== 4'b0) begin
                got_next = 1;
                vectors++;
                if (grant !== 4'b0100) begin
                    miscompares++;
                    $display("FAIL stall_next_grant got=%b exp=0100", grant);
                end
            end
            if (stall_err === 1'b1) pulses++;
            tick();
        end
        vectors++;
        if (pulses != 1 || !got_next) begin
            miscompares++;
            $display("FAIL stall_pulse got pulses=%0d next=%0d exp pulses=1 next=1", pulses, got_next);
        end
`else
        for (int c = 0; c < 102; c++) begin
            req_val = 4'b0100 | ((c < 2) ? 4'b0010 : 4'b0000);
            settle();
            vectors++;
            if (obs_vec() !== exp_vec) begin
                miscompares++;
                $display("FAIL hold_model cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec);
            end
            if (c >= 1) begin
                vectors++;
                if (grant !== 4'b0010 || stall_err !== 1'b0) begin
                    miscompares++;
                    $display("FAIL hold_grant cyc=%0d got grant=%b err=%b exp 0010/0", c, grant, stall_err);
                end
            end
            if (stall_err === 1'b1) pulses++;
            tick();
        end
        vectors++;
        if (pulses != 0) begin
            miscompares++;
            $display("FAIL hold_no_err got pulses=%0d exp=0", pulses);
        end
`endif
        req_val = '0;
    endtask

    task automatic test_random();
        reset_producers(2);
        rand_len = 1'b1;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) req_val[i] = ($urandom_range(0, 9) < 7);
            full_n = ($urandom_range(0, 3) != 0);
            rst    = ($urandom_range(0, 199) == 0);
            settle();
            vectors++;
            if (obs_vec() !== exp_vec) begin
                miscompares++;
                $display("FAIL random cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec);
            end
            tick();
        end
        rst = 1'b0; req_val = '0; full_n = 1'b1;
    endtask

    initial begin
        rst = 1'b1; req_val = '0; full_n = 1'b1; req_eom = '0; req_data = '0;
        m_busy = 0; m_err = 0; m_g = 0; m_ptr = 0; m_cnt = 0;
        test_reset();
        test_rotation();
        test_full_stall();
        test_lock_ignore();
        test_reset_mid();
        test_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
